// File: rtl/a2d_pkg.sv
// Shared constants, FSM state type and command-word helper for the A2D interface.
package a2d_pkg;

  localparam int SCLK_DIV_DEFAULT = 32;
  localparam int PORCH_LEN        = 16;
  localparam int GAP_LEN          = 32;
  localparam int XFER_BITS        = 16;
  localparam int CMD_CHNL_LSB     = 11;

  typedef enum logic [2:0] {
    IDLE,
    TX1,
    GAP,
    TX2,
    DONE
  } state_t;

  // The channel field sits in bits [13:11] of the command word; all other bits are zero.
  function automatic logic [15:0] chnl_cmd(input logic [2:0] chnl);
    return 16'(chnl) << CMD_CHNL_LSB;
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// One 16-bit SPI transaction: front porch, 16 SCLK periods (low then high), last high phase as back porch.
module spi_mstr16 #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);
  import a2d_pkg::*;

  localparam int XFER_LEN = PORCH_LEN + XFER_BITS * SCLK_DIV;
  localparam int CNT_W    = $clog2(XFER_LEN);
  localparam int DIV_W    = $clog2(SCLK_DIV);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(XFER_LEN - 1);
  localparam logic [CNT_W-1:0] PORCH_CNT = CNT_W'(PORCH_LEN);
  localparam logic [CNT_W-1:0] LAST_FALL = CNT_W'(XFER_LEN - SCLK_DIV);
  localparam logic [DIV_W-1:0] FALL_PH   = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] RISE_PH   = DIV_W'(SCLK_DIV / 2 - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase;
  logic [15:0]      tx_shft;
  logic [15:0]      rx_shft;
  logic             mosi_q;
  logic             fall_nxt;
  logic             rise_nxt;

  // Position inside the SCLK pattern, measured from the end of the front porch
  // (wraps negative during the porch, which the edge decodes below rely on).
  assign phase    = cnt - PORCH_CNT;
  assign fall_nxt = active && (phase[DIV_W-1:0] == FALL_PH) && (cnt < LAST_FALL);
  assign rise_nxt = active && (cnt >= PORCH_CNT) && (phase[DIV_W-1:0] == RISE_PH);

  assign done    = active && (cnt == LAST_CNT);
  assign SS_n    = ~active;
  assign SCLK    = ~(active && (cnt >= PORCH_CNT) && !phase[DIV_W-1]);
  assign MOSI    = mosi_q;
  assign rd_data = rx_shft;

  // Transaction counter and shift registers: MOSI moves on SCLK falls, MISO is captured on SCLK rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      tx_shft <= '0;
      rx_shft <= '0;
      mosi_q  <= 1'b0;
    end else if (!active) begin
      if (wrt) begin
        active  <= 1'b1;
        cnt     <= '0;
        tx_shft <= cmd;
        rx_shft <= '0;
        mosi_q  <= 1'b0;
      end
    end else begin
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
        mosi_q <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fall_nxt) begin
        mosi_q  <= tx_shft[15];
        tx_shft <= {tx_shft[14:0], 1'b0};
      end
      if (rise_nxt) begin
        rx_shft <= {rx_shft[14:0], MISO};
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion sequencer: channel-select transaction, 32-clk gap, then a read transaction.
module a2d_intf #(
  parameter int SCLK_DIV = a2d_pkg::SCLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        a2d_SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  import a2d_pkg::*;

  localparam int               GAP_W    = $clog2(GAP_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  state_t           state;
  state_t           nxt_state;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             wrt;
  logic             done;
  logic [15:0]      cmd;
  logic [15:0]      rd_data;
  logic             unused_rd_hi;

  // The upper nibble of the read word carries no result data.
  assign unused_rd_hi = ^rd_data[15:12];
  assign accept       = (state == IDLE) && strt_cnv;

  // The channel is captured by the SPI command register on the accepting edge,
  // so later chnnl changes cannot reach the bus.
  spi_mstr16 #(
    .SCLK_DIV(SCLK_DIV)
  ) u_spi (
    .clk    (clk),
    .rst    (rst),
    .wrt    (wrt),
    .cmd    (cmd),
    .MISO   (MISO),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (a2d_SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state decode; launches each transaction the cycle before slave select must fall.
  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    cmd       = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          wrt       = 1'b1;
          cmd       = chnl_cmd(chnnl);
          nxt_state = TX1;
        end
      end
      TX1:  if (done) nxt_state = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          wrt       = 1'b1;
          nxt_state = TX2;
        end
      end
      TX2:  if (done) nxt_state = DONE;
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Gap timer between the two transactions; idles at zero outside GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     gap_cnt <= '0;
    else if (state == GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_W'(1);
    else                                         gap_cnt <= '0;
  end

  // Completion flag and result: clear on acceptance, load once the read transaction has ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else if (accept) begin
      cnv_cmplt <= 1'b0;
    end else if (state == DONE) begin
      cnv_cmplt <= 1'b1;
      res       <= rd_data[11:0];
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed self-checking bench for a2d_intf with a behavioural SPI A2D slave.
module tb_a2d_intf;

  localparam int          CLK_PER    = 10;
  localparam logic [15:0] DUMMY_WORD = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        a2d_SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cyc      = 0;

  logic [15:0] ret_word = 16'h0000;
  logic [15:0] slv_word = 16'h0000;
  logic [15:0] mosi_cap = 16'h0000;
  int          slv_idx  = -1;
  logic [15:0] cap_words[$];
  int          low_lens[$];
  int          gaps[$];
  time         t_fall = 0;
  time         t_rise = 0;
  bit          have_rise = 1'b0;

  a2d_intf #(.SCLK_DIV(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .a2d_SS_n (a2d_SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  // Free-running system clock.
  always #(CLK_PER / 2) clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Slave select falling: choose reply word (dummy for the first of a pair) and measure the gap.
  always @(negedge a2d_SS_n) begin
    t_fall = $time;
    if (have_rise) gaps.push_back(int'((t_fall - t_rise) / CLK_PER));
    slv_word = (cap_words.size() % 2 == 0) ? DUMMY_WORD : ret_word;
    slv_idx  = 15;
    mosi_cap = '0;
  end

  // Slave select rising at the end of a completed transaction: log length and captured command.
  always @(posedge a2d_SS_n) begin
    if (!rst) begin
      t_rise    = $time;
      have_rise = 1'b1;
      low_lens.push_back(int'((t_rise - t_fall) / CLK_PER));
      cap_words.push_back(mosi_cap);
    end
  end

  // Slave drives the next reply bit on each SCLK fall.
  always @(negedge SCLK) begin
    if (!a2d_SS_n && slv_idx >= 0) MISO = slv_word[slv_idx];
  end

  // Slave captures MOSI on each SCLK rise.
  always @(posedge SCLK) begin
    if (!a2d_SS_n && !rst) begin
      mosi_cap = {mosi_cap[14:0], MOSI};
      slv_idx  = slv_idx - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ss_n"},   32'(a2d_SS_n),  32'h1);
    checkOutput({tag, "_sclk"},   32'(SCLK),      32'h1);
    checkOutput({tag, "_mosi"},   32'(MOSI),      32'h0);
    checkOutput({tag, "_cmplt"},  32'(cnv_cmplt), 32'h0);
    checkOutput({tag, "_res"},    32'(res),       32'h000);
  endtask

  // Runs one conversion; must be called just after a falling clk edge so back-to-back calls
  // raise strt_cnv in the very cycle the FSM re-enters IDLE.
  task automatic applyStimulus(input logic [2:0] ch, input logic [15:0] word, input bit poke);
    int          lat;
    bit          hold_ok;
    logic [11:0] old_res;
    logic [15:0] exp_cmd;
    exp_cmd = {2'b00, ch, 11'h000};
    old_res = res;
    lat     = -1;
    hold_ok = 1'b1;
    ret_word = word;
    cap_words.delete();
    low_lens.delete();
    gaps.delete();
    have_rise = 1'b0;

    strt_cnv = 1'b1;
    chnnl    = ch;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    chnnl    = ~ch;
    @(negedge clk);
    acc_cyc = cyc;
    checkOutput("cmplt_clr", 32'(cnv_cmplt), 32'h0);
    checkOutput("ss_fall",   32'(a2d_SS_n),  32'h0);

    for (int k = 1; k <= 1200; k++) begin
      if (poke && k == 300) begin
        strt_cnv = 1'b1;
        chnnl    = 3'b010;
      end else begin
        strt_cnv = 1'b0;
      end
      @(negedge clk);
      if (cnv_cmplt) begin
        lat = cyc - acc_cyc;
        break;
      end
      if (res !== old_res) hold_ok = 1'b0;
    end
    strt_cnv = 1'b0;

    checkOutput("latency",   32'(lat),     32'd1089);
    checkOutput("res",       32'(res),     32'(word[11:0]));
    checkOutput("res_hold",  32'(hold_ok), 32'h1);
    checkOutput("xfer_count", 32'(cap_words.size()), 32'd2);
    if (cap_words.size() == 2 && low_lens.size() == 2) begin
      checkOutput("tx1_cmd",  32'(cap_words[0]), 32'(exp_cmd));
      checkOutput("tx2_cmd",  32'(cap_words[1]), 32'h0000);
      checkOutput("ss_low1",  32'(low_lens[0]),  32'd528);
      checkOutput("ss_low2",  32'(low_lens[1]),  32'd528);
    end
    checkOutput("gap_count", 32'(gaps.size()), 32'd1);
    if (gaps.size() == 1) checkOutput("ss_gap", 32'(gaps[0]), 32'd32);
  endtask

  // Global time limit.
  initial begin
    #(CLK_PER * 60000);
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    rst      = 1'b1;
    strt_cnv = 1'b0;
    chnnl    = 3'b000;
    MISO     = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion on channel 5.
    applyStimulus(3'b101, 16'hFA5C, 1'b0);

    // Completion flag is a level; then reset mid-idle clears everything at once.
    repeat (5) @(negedge clk);
    checkOutput("cmplt_level", 32'(cnv_cmplt), 32'h1);
    checkOutput("res_level",   32'(res),       32'hA5C);
    #2 rst = 1'b1;
    #1 checkResetOutputs("idle_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Busy request at cycle 300 is ignored; then a back-to-back conversion.
    applyStimulus(3'b101, 16'hC3C7, 1'b1);
    applyStimulus(3'b110, 16'h7123, 1'b0);

    // Reset abort during TX2, then a fresh conversion returning zero.
    strt_cnv = 1'b1;
    chnnl    = 3'b011;
    ret_word = 16'hFFFF;
    cap_words.delete();
    @(posedge clk);
    #1 strt_cnv = 1'b0;
    repeat (700) @(negedge clk);
    checkOutput("abort_in_tx2", 32'(a2d_SS_n), 32'h0);
    #2 rst = 1'b1;
    #1 checkResetOutputs("abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(3'b000, 16'h9000, 1'b0);

    // Channel sweep, back to back, alternating full-scale and minimum codes.
    for (int ch = 0; ch < 8; ch++) begin
      applyStimulus(3'(ch), (ch % 2 == 0) ? 16'h5FFF : 16'hA001, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 Parameter SCLK_DIV, default 32, SCLK period in clk cycles; only 32 is supported.
REQ-002 Port clk, input, 1, system clock; all state is updated on the rising edge.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port strt_cnv, input, 1, single-cycle request for one conversion on channel chnnl.
REQ-005 Port chnnl, input, 3, A2D channel number; sampled on the cycle strt_cnv is accepted.
REQ-006 Port cnv_cmplt, output, 1, level flag: high when res is valid for the last accepted request.
REQ-007 Port res, output, 12, unsigned conversion result.
REQ-008 Port a2d_SS_n, output, 1, active-low SPI slave select.
REQ-009 Port SCLK, output, 1, SPI clock; idles high.
REQ-010 Port MOSI, output, 1, SPI data out.
REQ-011 Port MISO, input, 1, SPI data in.

Function
REQ-012 State machine states: IDLE, TX1, GAP, TX2, DONE.
- IDLE→TX1 on strt_cnv.
- TX1→GAP at the end of the first transaction.
- GAP→TX2 after 32 clk.
- TX2→DONE at the end of the second transaction.
- DONE→IDLE after one clk.
REQ-013 strt_cnv is accepted only in IDLE; it is ignored in all other states, and chnnl changes while busy have no effect.
REQ-014 On acceptance, chnnl is latched, cnv_cmplt clears on the next cycle, and a2d_SS_n falls on the next cycle.
REQ-015 Each 16-bit transaction has this timing:
- a2d_SS_n stays low for exactly 528 clk.
- SCLK is held high for a 16-clk front porch.
- Then come 16 SCLK periods, each 16 clk low followed by 16 clk high.
- The high phase of the last period serves as the back porch.
- a2d_SS_n then rises.
REQ-016 MOSI is updated on each SCLK falling edge, MSB first; MISO is sampled on the clk cycle of each SCLK rising edge, MSB first.
REQ-017 The TX1 command word is {2'b00, chnnl_latched, 11'h000}; the data received in TX1 is discarded (dummy read).
REQ-018 The TX2 command word is 16'h0000; res is loaded with the received bits [11:0], and bits [15:12] are ignored.
REQ-019 a2d_SS_n is high for exactly 32 clk between TX1 and TX2.
REQ-020 cnv_cmplt goes high 1089 clk after the strt_cnv acceptance edge, and res updates on the same edge.
REQ-021 cnv_cmplt stays high until the next accepted strt_cnv; res holds its value until the next completion.
REQ-022 strt_cnv asserted in the same cycle the FSM enters IDLE from DONE is accepted.
REQ-023 In IDLE, MOSI is 0, SCLK is 1 and a2d_SS_n is 1.
REQ-024 No arithmetic overflow is possible; the SCLK divider and the bit counter wrap only inside the active states.

Reset
REQ-025 While rst is high, outputs are immediately: a2d_SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, FSM=IDLE, and all counters are 0.
REQ-026 Reset asserted mid-transaction aborts the transaction with no partial res update; the first strt_cnv after reset release behaves per REQ-014.

Structure
REQ-027 Shared package a2d_pkg holds:
- SCLK_DIV;
- the porch and gap lengths (16, 32);
- the FSM state enum;
- the command-word channel field position.
REQ-028 Sub-module spi_mstr16 performs one 16-bit transaction.
- Ports: wrt, cmd[15:0], MISO; done, rd_data[15:0], SS_n, SCLK, MOSI.
- a2d_intf sequences two spi_mstr16 transactions per conversion.

Verification
REQ-029 Reset scenario: assert rst mid-idle → all outputs match REQ-025 within the same cycle.
REQ-030 Basic conversion: strt_cnv with chnnl=3'b101, SPI slave model returns 16'hFA5C in TX2 → required response:
- captured TX1 MOSI word is 16'h2800;
- a2d_SS_n low pulses of 528 clk, separated by a 32-clk gap;
- res=12'hA5C;
- cnv_cmplt rises 1089 clk after acceptance.
REQ-031 Busy scenario: a second strt_cnv with chnnl=3'b010 at cycle 300 → ignored; TX1 word stays 16'h2800, and exactly two transactions occur.
REQ-032 Reset-abort scenario: rst pulse during TX2, then a new strt_cnv with chnnl=3'b000 and the model returning 12'h000 → res=12'h000, cnv_cmplt=1 after 1089 clk, and no stale value ever appears.
REQ-033 Channel sweep: channels 0 through 7 in sequence, model returning 12'hFFF then 12'h001 alternately →
- command words equal chnnl<<11;
- res tracks the model value;
- cnv_cmplt drops one cycle after each acceptance.
REQ-034 Back-to-back scenario: strt_cnv on the cycle the FSM returns to IDLE → accepted; the old res is held until the new completion.
